cmp_pipe: RTL and testbench
===========================

CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width; legal 8..64.
REQ-002 SHALL have parameter STAGES, default 2: pipeline depth; legal values 1 or 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port A  input  WIDTH  first operand.
REQ-008 SHALL have port B  input  WIDTH  second operand.
REQ-009 SHALL have port Sign  input  1  1 = signed compare, 0 = unsigned; affects LT only.
REQ-010 SHALL have port Mode  input  3  compare operation, captured with the beat.
REQ-011 SHALL have port out_valid  output  1  result beat present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port S  output  WIDTH  result: 1 (zero-extended) if condition true, else 0.
REQ-014 SHALL have ports Z, V, N  output  1 each  ALU flags.
REQ-015 SHALL have port err  output  1  sticky: reserved Mode was accepted.

Function
REQ-016 Mode encodings SHALL be: 000 EQ (A==B), 001 NEQ (A!=B), 010 LT (A<B, signedness per Sign), 011 LEZ (A<=0 signed), 100 GTZ (A>0 signed), 101 LTZ (A<0 signed), 110 GEZ (A>=0 signed), 111 reserved.
REQ-017 Reserved mode SHALL give S=0, Z=1 and set err; the beat still flows normally.
REQ-018 Z SHALL equal (S==0); V and N SHALL be 0 on every result beat.
REQ-019 Signed LT SHALL be computed from a WIDTH+1-bit subtraction A-B; the result SHALL be correct when the subtraction overflows (e.g. A=most negative, B=1).
REQ-020 Latency SHALL be STAGES cycles from acceptance to out_valid, with no bubbles when out_ready stays 1.
REQ-021 STAGES=2: stage 1 SHALL register the subtract result, equality, A-zero and A-sign bits and Mode; stage 2 SHALL register S, Z, V and N.
REQ-022 STAGES=1: one register SHALL hold the final outputs.
REQ-023 Throughput SHALL be one beat per cycle.
REQ-024 in_ready SHALL be high when stage 1 is empty or will advance this cycle, i.e. !s1_valid || !(out_valid && !out_ready).
REQ-025 While out_valid && !out_ready, S, Z, V, N and out_valid SHALL hold their values, and no stage SHALL advance.
REQ-026 A beat SHALL never be dropped or duplicated; beats SHALL be delivered in acceptance order.
REQ-027 Simultaneous accept and emit in one cycle SHALL be legal and SHALL keep occupancy unchanged.
REQ-028 out_valid SHALL not depend combinationally on in_valid; in_ready SHALL depend only on registered state and out_ready.

Reset
REQ-029 On reset: all stage-valid bits = 0, out_valid=0, S=0, Z=1, V=0, N=0, err=0.
REQ-030 in_ready SHALL be 1 during and after reset.
REQ-031 Reset mid-operation SHALL discard all in-flight beats without emitting them; the first beat accepted after reset SHALL be processed normally.
REQ-032 err SHALL clear only on reset.

Structure
REQ-033 Package cmp_pkg SHALL hold the Mode encoding constants and a cmp_mode_t typedef; the bench SHALL use the same package.
REQ-034 Sub-module cmp_decide SHALL be combinational: inputs are the stage-1 fields and Mode, outputs are S, Z, V, N; it SHALL be reused in both STAGES configurations.

Verification
REQ-035 EQ: A=0x12345678, B=0x12345678, Mode=000, out_ready=1 -> two cycles later S=1, Z=0, V=0, N=0.
REQ-036 Signed vs unsigned LT: A=0xFFFFFFFF, B=1, Mode=010 -> Sign=1 gives S=1, Z=0; Sign=0 gives S=0, Z=1.
REQ-037 Overflow LT: A=0x80000000, B=0x00000001, Sign=1, Mode=010 -> S=1; A=0x7FFFFFFF, B=0x80000000, Sign=1 -> S=0.
REQ-038 Backpressure: stream 5 beats back-to-back, hold out_ready=0 for cycles 3-6 -> in_ready falls once both stages are full; all 5 results arrive in order; S is stable while stalled.
REQ-039 Zero-compare and reserved mode: A=0 gives LEZ=1, GTZ=0, LTZ=0, GEZ=1; Mode=111 -> S=0, Z=1, err=1 until reset.
REQ-040 Reset with 2 beats in flight -> next cycle out_valid=0 and in_ready=1, no stale beat emitted; run at STAGES=1 and STAGES=2.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare-mode encoding for the cmp_pipe datapath and its bench.
package cmp_pkg;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'b000,
        CMP_NEQ  = 3'b001,
        CMP_LT   = 3'b010,
        CMP_LEZ  = 3'b011,
        CMP_GTZ  = 3'b100,
        CMP_LTZ  = 3'b101,
        CMP_GEZ  = 3'b110,
        CMP_RSVD = 3'b111
    } cmp_mode_t;

    localparam int CMP_MODE_W = 3;

    function automatic logic cmp_is_reserved(cmp_mode_t m);
        return m == CMP_RSVD;
    endfunction

endpackage

// File: rtl/cmp_decide.sv
// Combinational result decode: picks the condition selected by mode from the
// precomputed compare fields and forms the S/Z/V/N outputs.
module cmp_decide
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             lt,
    input  logic             eq,
    input  logic             a_zero,
    input  logic             a_sign,
    input  cmp_mode_t        mode,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             v,
    output logic             n
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (mode)
            CMP_EQ:  cond = eq;
            CMP_NEQ: cond = !eq;
            CMP_LT:  cond = lt;
            CMP_LEZ: cond = a_sign || a_zero;
            CMP_GTZ: cond = !a_sign && !a_zero;
            CMP_LTZ: cond = a_sign;
            CMP_GEZ: cond = !a_sign;
            default: cond = 1'b0;
        endcase
    end

    assign s = {{(WIDTH-1){1'b0}}, cond};
    assign z = !cond;
    assign v = 1'b0;
    assign n = 1'b0;

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined comparator with valid/ready flow control on both sides.
// Handshake: a beat moves when valid && ready; an offered beat holds until taken.
module cmp_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    input  logic [2:0]       Mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             err
);

    // Operands are extended by one bit (sign or zero) so the subtraction can
    // never overflow; its top bit is then exactly A<B for either signedness.
    logic [WIDTH:0] a_ext, b_ext, diff;
    logic           f_lt, f_eq, f_az, f_as;
    logic           unused_diff_bits;

    assign a_ext = {Sign & A[WIDTH-1], A};
    assign b_ext = {Sign & B[WIDTH-1], B};
    assign diff  = a_ext - b_ext;
    assign f_lt  = diff[WIDTH];
    assign f_eq  = (A == B);
    assign f_az  = (A == '0);
    assign f_as  = A[WIDTH-1];
    assign unused_diff_bits = ^diff[WIDTH-1:0];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d, v_q, v_d, n_q, n_d;
    logic             err_q, err_d;

    logic             stall, accept, out_adv, out_vin;
    logic             d_lt, d_eq, d_az, d_as;
    cmp_mode_t        d_mode;
    logic [WIDTH-1:0] dec_s;
    logic             dec_z, dec_v, dec_n;

    assign stall  = out_valid_q && !out_ready;
    assign accept = in_valid && in_ready;

    if (STAGES == 2) begin : g_two
        logic      s1_valid_q, s1_valid_d;
        logic      s1_lt_q, s1_eq_q, s1_az_q, s1_as_q;
        logic      s1_lt_d, s1_eq_d, s1_az_d, s1_as_d;
        cmp_mode_t s1_mode_q, s1_mode_d;

        assign in_ready = !s1_valid_q || !stall;

        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_lt_d    = s1_lt_q;
            s1_eq_d    = s1_eq_q;
            s1_az_d    = s1_az_q;
            s1_as_d    = s1_as_q;
            s1_mode_d  = s1_mode_q;
            if (in_ready) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_lt_d   = f_lt;
                    s1_eq_d   = f_eq;
                    s1_az_d   = f_az;
                    s1_as_d   = f_as;
                    s1_mode_d = cmp_mode_t'(Mode);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_lt_q    <= 1'b0;
                s1_eq_q    <= 1'b0;
                s1_az_q    <= 1'b0;
                s1_as_q    <= 1'b0;
                s1_mode_q  <= CMP_EQ;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_lt_q    <= s1_lt_d;
                s1_eq_q    <= s1_eq_d;
                s1_az_q    <= s1_az_d;
                s1_as_q    <= s1_as_d;
                s1_mode_q  <= s1_mode_d;
            end
        end

        assign d_lt    = s1_lt_q;
        assign d_eq    = s1_eq_q;
        assign d_az    = s1_az_q;
        assign d_as    = s1_as_q;
        assign d_mode  = s1_mode_q;
        assign out_adv = !stall;
        assign out_vin = s1_valid_q;
    end else begin : g_one
        assign in_ready = !stall;
        assign d_lt     = f_lt;
        assign d_eq     = f_eq;
        assign d_az     = f_az;
        assign d_as     = f_as;
        assign d_mode   = cmp_mode_t'(Mode);
        assign out_adv  = !stall;
        assign out_vin  = in_valid;
    end

    cmp_decide #(.WIDTH(WIDTH)) u_decide (
        .lt     (d_lt),
        .eq     (d_eq),
        .a_zero (d_az),
        .a_sign (d_as),
        .mode   (d_mode),
        .s      (dec_s),
        .z      (dec_z),
        .v      (dec_v),
        .n      (dec_n)
    );

    // Result data only changes when a real beat lands, so idle S/Z keep the
    // last delivered result.
    always_comb begin
        out_valid_d = out_valid_q;
        s_d         = s_q;
        z_d         = z_q;
        v_d         = v_q;
        n_d         = n_q;
        if (out_adv) begin
            out_valid_d = out_vin;
            if (out_vin) begin
                s_d = dec_s;
                z_d = dec_z;
                v_d = dec_v;
                n_d = dec_n;
            end
        end
        err_d = err_q || (accept && cmp_is_reserved(cmp_mode_t'(Mode)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            z_q         <= 1'b1;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            z_q         <= z_d;
            v_q         <= v_d;
            n_q         <= n_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign Z         = z_q;
    assign V         = v_q;
    assign N         = n_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Directed bench for cmp_pipe: one STAGES=2 and one STAGES=1 instance share
// stimulus; each has its own expected-result queue fed on its own accepts.
module tb_cmp_pipe;
  import cmp_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] A, B;
  logic        Sign;
  logic [2:0]  Mode;

  logic        ir2, ov2, z2, v2, n2, err2;
  logic [31:0] s2;
  logic        ir1, ov1, z1, v1, n1, err1;
  logic [31:0] s1;

  int n_checks = 0;
  int n_pass   = 0;
  int rx2 = 0;
  int rx1 = 0;

  logic [34:0] exp_cur;
  logic [34:0] exp_q2[$];
  logic [34:0] exp_q1[$];

  cmp_pipe #(.WIDTH(32), .STAGES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
    .A(A), .B(B), .Sign(Sign), .Mode(Mode),
    .out_valid(ov2), .out_ready(out_ready),
    .S(s2), .Z(z2), .V(v2), .N(n2), .err(err2)
  );

  cmp_pipe #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .A(A), .B(B), .Sign(Sign), .Mode(Mode),
    .out_valid(ov1), .out_ready(out_ready),
    .S(s1), .Z(z1), .V(v1), .N(n1), .err(err1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [34:0] pk(input logic s);
    return {31'b0, s, !s, 1'b0, 1'b0};
  endfunction

  // scoreboard: pop on delivery, push on accept (per instance)
  always @(negedge clk) begin
    if (!reset) begin
      if (ov2 && out_ready) begin
        rx2++;
        if (exp_q2.size() == 0) check("u2_extra_beat", 1, 0);
        else check("u2_beat", {s2, z2, v2, n2}, exp_q2.pop_front());
      end
      if (ov1 && out_ready) begin
        rx1++;
        if (exp_q1.size() == 0) check("u1_extra_beat", 1, 0);
        else check("u1_beat", {s1, z1, v1, n1}, exp_q1.pop_front());
      end
      if (in_valid && ir2) exp_q2.push_back(exp_cur);
      if (in_valid && ir1) exp_q1.push_back(exp_cur);
    end
  end

  // driver: offer one beat and hold it until the STAGES=2 instance takes it
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sg,
                      input cmp_mode_t md, input logic s_exp);
    int n;
    A = a; B = b; Sign = sg; Mode = md;
    exp_cur = pk(s_exp);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ir2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
    check("q2_empty", exp_q2.size(), 0);
    check("q1_empty", exp_q1.size(), 0);
  endtask

  logic [31:0] s_hold;
  logic        saw_low;
  int          rx2_base, rx1_base;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; Sign = 1'b0; Mode = CMP_EQ; exp_cur = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready2", ir2, 1);
    check("rst_in_ready1", ir1, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_state2", {ov2, s2, z2, v2, n2, err2}, {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    check("rst_state1", {ov1, s1, z1, v1, n1, err1}, {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});

    // EQ with latency check: one cycle after accept only STAGES=1 has it
    send(32'h12345678, 32'h12345678, 1'b0, CMP_EQ, 1'b1);
    check("eq_lat1_u2_idle", ov2, 0);
    check("eq_lat1_u1", {ov1, s1, z1}, {1'b1, 32'h1, 1'b0});
    @(posedge clk); #1;
    check("eq_lat2_u2", {ov2, s2, z2, v2, n2}, {1'b1, 32'h1, 1'b0, 1'b0, 1'b0});

    // LT signedness and overflow cases, back-to-back
    send(32'hFFFFFFFF, 32'h00000001, 1'b1, CMP_LT, 1'b1);
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, CMP_LT, 1'b0);
    send(32'h80000000, 32'h00000001, 1'b1, CMP_LT, 1'b1);
    send(32'h7FFFFFFF, 32'h80000000, 1'b1, CMP_LT, 1'b0);
    send(32'h7FFFFFFF, 32'h80000000, 1'b0, CMP_LT, 1'b1);
    send(32'h00000005, 32'h00000006, 1'b0, CMP_NEQ, 1'b1);
    send(32'h00000005, 32'h00000006, 1'b0, CMP_EQ, 1'b0);
    // zero compares on A = 0, most negative, and 1
    send(32'h00000000, 32'h0, 1'b0, CMP_LEZ, 1'b1);
    send(32'h00000000, 32'h0, 1'b0, CMP_GTZ, 1'b0);
    send(32'h00000000, 32'h0, 1'b0, CMP_LTZ, 1'b0);
    send(32'h00000000, 32'h0, 1'b0, CMP_GEZ, 1'b1);
    send(32'h80000000, 32'h0, 1'b0, CMP_LEZ, 1'b1);
    send(32'h80000000, 32'h0, 1'b0, CMP_GTZ, 1'b0);
    send(32'h80000000, 32'h0, 1'b0, CMP_LTZ, 1'b1);
    send(32'h80000000, 32'h0, 1'b0, CMP_GEZ, 1'b0);
    send(32'h00000001, 32'h0, 1'b0, CMP_LEZ, 1'b0);
    send(32'h00000001, 32'h0, 1'b0, CMP_GTZ, 1'b1);
    drain();
    check("err_clear_before_rsvd", {err2, err1}, 2'b00);

    // reserved mode: S=0, Z=1, beat flows, err sticks
    send(32'h00000003, 32'h00000003, 1'b0, CMP_RSVD, 1'b0);
    drain();
    check("err_set", {err2, err1}, 2'b11);
    send(32'h00000003, 32'h00000003, 1'b0, CMP_EQ, 1'b1);
    drain();
    check("err_sticky", {err2, err1}, 2'b11);

    // backpressure: 5 back-to-back beats, out_ready low for 4 cycles
    rx2_base = rx2;
    fork
      begin
        send(32'h00000010, 32'h00000010, 1'b0, CMP_EQ, 1'b1);
        send(32'h00000010, 32'h00000011, 1'b0, CMP_EQ, 1'b0);
        send(32'h00000001, 32'h00000002, 1'b0, CMP_LT, 1'b1);
        send(32'hFFFFFFFE, 32'h00000002, 1'b1, CMP_LT, 1'b1);
        send(32'hFFFFFFFE, 32'h00000002, 1'b0, CMP_LT, 1'b0);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        s_hold  = s2;
        saw_low = !ir2;
        repeat (4) begin
          @(negedge clk);
          if (!ir2) saw_low = 1'b1;
          check("stall_ov_hold", ov2, 1);
          check("stall_s_hold", s2, s_hold);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_fell", saw_low, 1);
    drain();
    check("bp_beat_count", rx2 - rx2_base, 5);

    // reset with two beats in flight
    out_ready = 1'b0;
    send(32'h00000020, 32'h00000020, 1'b0, CMP_EQ, 1'b1);
    send(32'h00000021, 32'h00000020, 1'b0, CMP_EQ, 1'b0);
    reset = 1'b1;
    exp_q2.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_flight_u2", {ov2, ir2, err2}, 3'b010);
    check("rst_flight_u1", {ov1, ir1, err1}, 3'b010);
    out_ready = 1'b1;
    rx2_base = rx2;
    rx1_base = rx1;
    repeat (4) @(posedge clk); #1;
    check("no_stale_u2", rx2 - rx2_base, 0);
    check("no_stale_u1", rx1 - rx1_base, 0);
    send(32'h00000009, 32'h00000009, 1'b0, CMP_EQ, 1'b1);
    drain();
    check("post_rst_u2", rx2 - rx2_base, 1);
    check("post_rst_u1", rx1 - rx1_base, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
